// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - memory-mapped GPIO controller: switches, debounced keys, LEDs, key interrupt
module gpio_ctrl #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4,
    parameter int N_LED           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      gpio_address,
    input  logic [31:0]      gpio_data_write,
    input  logic             gpio_write_enable,
    input  logic             gpio_read_enable,
    output logic             gpio_rdata_valid,
    output logic [31:0]      gpio_data_read,
    input  logic [N_SW-1:0]  sw,
    input  logic [N_KEY-1:0] key,
    output logic [N_LED-1:0] ledr,
    output logic             irq
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] ADDR_SW       = 32'h00;
    localparam logic [31:0] ADDR_LEDR     = 32'h04;
    localparam logic [31:0] ADDR_KEY      = 32'h08;
    localparam logic [31:0] ADDR_LED_SET  = 32'h0C;
    localparam logic [31:0] ADDR_LED_CLR  = 32'h10;
    localparam logic [31:0] ADDR_LED_TGL  = 32'h14;
    localparam logic [31:0] ADDR_KEY_EDGE = 32'h18;
    localparam logic [31:0] ADDR_IRQ_EN   = 32'h1C;

    logic [N_SW-1:0]  r_sw_s1, r_sw_s2;
    logic [N_KEY-1:0] r_key_s1, r_key_s2;
    logic [N_KEY-1:0] r_key_db;
    logic [CW-1:0]    r_cnt [N_KEY];
    logic [N_LED-1:0] r_led;
    logic [N_KEY-1:0] r_key_edge;
    logic [N_KEY-1:0] r_irq_en;
    logic             r_irq;
    logic [31:0]      r_rdata;
    logic             r_rvalid;

    logic [N_KEY-1:0] w_accept;
    logic [N_KEY-1:0] w_press;
    logic [N_KEY-1:0] w_w1c;
    logic [N_LED-1:0] w_led_wd;
    logic [N_KEY-1:0] w_key_wd;
    logic [31:0]      w_rdata;
    logic             w_wr_ledr, w_wr_set, w_wr_clr, w_wr_tgl, w_wr_edge, w_wr_en;
    logic             w_unused;

    assign w_wr_ledr = gpio_write_enable && (gpio_address == ADDR_LEDR);
    assign w_wr_set  = gpio_write_enable && (gpio_address == ADDR_LED_SET);
    assign w_wr_clr  = gpio_write_enable && (gpio_address == ADDR_LED_CLR);
    assign w_wr_tgl  = gpio_write_enable && (gpio_address == ADDR_LED_TGL);
    assign w_wr_edge = gpio_write_enable && (gpio_address == ADDR_KEY_EDGE);
    assign w_wr_en   = gpio_write_enable && (gpio_address == ADDR_IRQ_EN);

    assign w_led_wd = gpio_data_write[N_LED-1:0];
    assign w_key_wd = gpio_data_write[N_KEY-1:0];
    assign w_unused = ^gpio_data_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= '1;
            r_key_s2 <= '1;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
        end
    end

    // A key change is accepted once the synced level has differed for DEBOUNCE_CYCLES edges.
    always_comb begin
        for (int i = 0; i < N_KEY; i++) begin
            w_accept[i] = (r_key_s2[i] != r_key_db[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    assign w_press = w_accept & ~r_key_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_db <= '1;
            for (int i = 0; i < N_KEY; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEY; i++) begin
                if (r_key_s2[i] == r_key_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_key_db[i] <= r_key_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led <= '0;
        end else if (w_wr_ledr) begin
            r_led <= w_led_wd;
        end else if (w_wr_set) begin
            r_led <= r_led | w_led_wd;
        end else if (w_wr_clr) begin
            r_led <= r_led & ~w_led_wd;
        end else if (w_wr_tgl) begin
            r_led <= r_led ^ w_led_wd;
        end
    end

    // A press landing in the same cycle as its W1C keeps the flag set.
    assign w_w1c = w_wr_edge ? w_key_wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_edge <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_key_edge <= (r_key_edge & ~w_w1c) | w_press;
            if (w_wr_en) begin
                r_irq_en <= w_key_wd;
            end
            r_irq <= |(r_key_edge & r_irq_en);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (gpio_address)
            ADDR_SW:       w_rdata[N_SW-1:0]  = r_sw_s2;
            ADDR_LEDR:     w_rdata[N_LED-1:0] = r_led;
            ADDR_KEY:      w_rdata[N_KEY-1:0] = r_key_db;
            ADDR_KEY_EDGE: w_rdata[N_KEY-1:0] = r_key_edge;
            ADDR_IRQ_EN:   w_rdata[N_KEY-1:0] = r_irq_en;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= gpio_read_enable;
            r_rdata  <= gpio_read_enable ? w_rdata : 32'h0;
        end
    end

    assign gpio_data_read   = r_rdata;
    assign gpio_rdata_valid = r_rvalid;
    assign ledr             = r_led;
    assign irq              = r_irq;

endmodule
